// File: rtl/fft_pkg.sv
// Shared types and constants for the 16-lane radix-2 FFT datapath.
package fft_pkg;

  localparam int unsigned SIG   = 1;
  localparam int unsigned INT   = 2;
  localparam int unsigned FLT   = 6;
  localparam int unsigned WIDTH = SIG + INT + FLT;
  localparam int unsigned LANES = 16;

  typedef struct packed {
    logic signed [WIDTH-1:0] i;
    logic signed [WIDTH-1:0] q;
  } cplx_t;

  typedef cplx_t [LANES-1:0] lane_vec_t;

  typedef enum logic {
    FILL = 1'b0,
    PAIR = 1'b1
  } buf_state_e;

endpackage

// File: rtl/stage_dly_mem.sv
// Single-port half-frame delay memory; written in FILL, read in PAIR.
module stage_dly_mem #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned W     = 288,
  parameter int unsigned AW    = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [AW-1:0] addr_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q;

  // Storage array: plain write port, no reset so it maps onto RAM.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  // Registered read; holds its value when no read is issued.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/bfly_in_buf.sv
// Input pairing buffer for one 16-lane radix-2 FFT stage: stores the first
// half-frame, then presents stored/live pairs to the butterfly.
module bfly_in_buf
  import fft_pkg::*;
#(
  parameter int unsigned SIG   = fft_pkg::SIG,
  parameter int unsigned INT   = fft_pkg::INT,
  parameter int unsigned FLT   = fft_pkg::FLT,
  parameter int unsigned WIDTH = SIG + INT + FLT,
  parameter int unsigned LANES = fft_pkg::LANES,
  parameter int unsigned DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    clr,
  input  logic                    din_valid,
  input  logic signed [WIDTH-1:0] din_i   [0:LANES-1],
  input  logic signed [WIDTH-1:0] din_q   [0:LANES-1],
  output logic                    bfly_en,
  output logic signed [WIDTH-1:0] dout1_i [0:LANES-1],
  output logic signed [WIDTH-1:0] dout1_q [0:LANES-1],
  output logic signed [WIDTH-1:0] dout2_i [0:LANES-1],
  output logic signed [WIDTH-1:0] dout2_q [0:LANES-1],
  output logic                    frame_done,
  output logic                    gap_err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned MW = 2 * LANES * WIDTH;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  buf_state_e state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic mem_we, mem_re;
  logic [MW-1:0] mem_wdata, mem_rdata;
  logic bfly_en_q, frame_done_q, gap_err_q;
  logic signed [WIDTH-1:0] dout2_i_q [0:LANES-1];
  logic signed [WIDTH-1:0] dout2_q_q [0:LANES-1];

  // Phase and half-frame counter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= FILL;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next phase/count and memory strobes; clr beats a coincident valid.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mem_we  = 1'b0;
    mem_re  = 1'b0;
    if (clr) begin
      state_d = FILL;
      cnt_d   = '0;
    end else if (din_valid) begin
      cnt_d = cnt_q + AW'(1);
      if (state_q == FILL) begin
        mem_we = 1'b1;
        if (cnt_q == LAST) begin
          state_d = PAIR;
          cnt_d   = '0;
        end
      end else begin
        mem_re = 1'b1;
        if (cnt_q == LAST) begin
          state_d = FILL;
          cnt_d   = '0;
        end
      end
    end
  end

  // Pack all lanes into one memory word: lane j occupies {q, i}.
  always_comb begin
    mem_wdata = '0;
    for (int unsigned j = 0; j < LANES; j++) begin
      mem_wdata[(2*j)*WIDTH   +: WIDTH] = din_i[j];
      mem_wdata[(2*j+1)*WIDTH +: WIDTH] = din_q[j];
    end
  end

  stage_dly_mem #(
    .DEPTH (DEPTH),
    .W     (MW),
    .AW    (AW)
  ) u_mem (
    .clk_i   (clk),
    .rst_ni  (rstn),
    .we_i    (mem_we),
    .re_i    (mem_re),
    .addr_i  (cnt_q),
    .wdata_i (mem_wdata),
    .rdata_o (mem_rdata)
  );

  // The RAM read register doubles as the dout1 register.
  always_comb begin
    for (int unsigned j = 0; j < LANES; j++) begin
      dout1_i[j] = mem_rdata[(2*j)*WIDTH   +: WIDTH];
      dout1_q[j] = mem_rdata[(2*j+1)*WIDTH +: WIDTH];
    end
  end

  // Live-path register, loaded on the same cycle as the RAM read.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned j = 0; j < LANES; j++) begin
        dout2_i_q[j] <= '0;
        dout2_q_q[j] <= '0;
      end
    end else if (mem_re) begin
      for (int unsigned j = 0; j < LANES; j++) begin
        dout2_i_q[j] <= din_i[j];
        dout2_q_q[j] <= din_q[j];
      end
    end
  end

  // Pair strobe, frame completion pulse and sticky gap flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bfly_en_q    <= 1'b0;
      frame_done_q <= 1'b0;
      gap_err_q    <= 1'b0;
    end else begin
      bfly_en_q    <= mem_re;
      frame_done_q <= mem_re && (cnt_q == LAST);
      if (clr)
        gap_err_q <= 1'b0;
      else if (state_q == PAIR && !din_valid && cnt_q != '0)
        gap_err_q <= 1'b1;
    end
  end

  assign bfly_en    = bfly_en_q;
  assign frame_done = frame_done_q;
  assign gap_err    = gap_err_q;
  assign dout2_i    = dout2_i_q;
  assign dout2_q    = dout2_q_q;

endmodule
